// File: rtl/dds_out_arbiter.sv
// Shares one registered M-bit sample path between two DDS channels.
// Channels hand samples over with req/ack; the output stage takes them with valid/ready.
module dds_out_arbiter #(
  parameter int M       = 12,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [M-1:0]       data0,
  input  logic               req1,
  input  logic [M-1:0]       data1,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               ack0,
  output logic               ack1,
  output logic               sel,
  output logic [M-1:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t             state_q;
  logic               ack0_q;
  logic               ack1_q;
  logic               sel_q;
  logic [M-1:0]       out_data_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               last_served_q;
  logic [DWELL_W-1:0] dwell_cnt_q;

  logic               winner_d;
  logic [M-1:0]       win_data_d;

  // Winner for the next grant; round-robin ties go to the channel not served last.
  always_comb begin
    winner_d = 1'b0;
    if (req0 && req1) begin
      if (mode) begin
        winner_d = 1'b0;
      end else begin
        winner_d = ~last_served_q;
      end
    end else if (req1) begin
      winner_d = 1'b1;
    end else begin
      winner_d = 1'b0;
    end
    win_data_d = winner_d ? data1 : data0;
  end

  // Arbitration FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      sel_q         <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      last_served_q <= 1'b1;
      dwell_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q     <= XFER;
            sel_q       <= winner_d;
            out_data_q  <= win_data_d;
            out_valid_q <= 1'b1;
            ack0_q      <= ~winner_d;
            ack1_q      <= winner_d;
            busy_q      <= 1'b1;
            dwell_cnt_q <= dwell;
          end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        XFER: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (out_valid_q && out_ready) begin
            last_served_q <= sel_q;
            out_valid_q   <= 1'b0;
            if (dwell_cnt_q != '0) begin
              state_q <= DWELL;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        DWELL: begin
          ack0_q      <= 1'b0;
          ack1_q      <= 1'b0;
          out_valid_q <= 1'b0;
          // A count of 1 is the last idle cycle, so dwell=N yields N cycles here.
          if (dwell_cnt_q <= DWELL_W'(1)) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            dwell_cnt_q <= '0;
          end else begin
            busy_q      <= 1'b1;
            dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          ack0_q      <= 1'b0;
          ack1_q      <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          dwell_cnt_q <= '0;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dds_out_arbiter.sv
// Scoreboard bench for dds_out_arbiter: a transaction-level model predicts grant
// cycles, owners and samples; a negedge monitor pops and compares.
module tb_dds_out_arbiter;
  localparam int M    = 12;
  localparam int DW   = 4;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, mode, out_ready;
  logic [M-1:0]  data0, data1;
  logic [DW-1:0] dwell;
  logic          ack0, ack1, sel, out_valid, busy;
  logic [M-1:0]  out_data;

  typedef struct packed {
    int         cyc;
    logic       ch;
    logic [M-1:0] data;
  } grant_t;

  grant_t       sb_q[$];
  grant_t       mon_g;
  grant_t       new_g;
  bit           exp_valid [0:MAXC+31];
  bit           exp_busy  [0:MAXC+31];
  bit           exp_zero  [0:MAXC+31];
  bit           exp_sel   [0:MAXC+31];
  logic [M-1:0] exp_data  [0:MAXC+31];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit done = 1'b0;

  // Model state: outstanding transfer, first free cycle, last served channel.
  bit           m_pending;
  bit           m_ch;
  logic [M-1:0] m_data;
  int           m_dwell;
  int           m_free;
  bit           m_last;
  bit           rearm0, rearm1, fixed_data;

  dds_out_arbiter #(.M(M), .DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .mode(mode), .dwell(dwell),
    .ack0(ack0), .ack1(ack1), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model for the inputs of the current cycle.
  task automatic run_model();
    bit ch;
    if (m_pending) begin
      exp_valid[cyc] = 1'b1;
      exp_busy[cyc]  = 1'b1;
      exp_sel[cyc]   = m_ch;
      exp_data[cyc]  = m_data;
      if (out_ready && rst_n) begin
        m_pending = 1'b0;
        m_last    = m_ch;
        for (int k = 1; k <= m_dwell; k++) exp_busy[cyc+k] = 1'b1;
        m_free = cyc + m_dwell + 1;
      end
    end
    if (!rst_n) begin
      m_pending = 1'b0;
      m_last    = 1'b1;
      m_free    = cyc + 1;
      for (int k = 1; k <= 20; k++) begin
        exp_valid[cyc+k] = 1'b0;
        exp_busy[cyc+k]  = 1'b0;
      end
      exp_zero[cyc+1] = 1'b1;
    end else if (!m_pending && cyc >= m_free && (req0 || req1)) begin
      if (req0 && req1) ch = mode ? 1'b0 : !m_last;
      else              ch = req1;
      new_g.cyc  = cyc + 1;
      new_g.ch   = ch;
      new_g.data = ch ? data1 : data0;
      sb_q.push_back(new_g);
      m_pending = 1'b1;
      m_ch      = ch;
      m_data    = new_g.data;
      m_dwell   = int'(dwell);
    end
  endtask

  // Commit the current cycle to the model, advance, and let requesters react to ack.
  task automatic next();
    run_model();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget at cycle %0d: got %0d, expected below %0d", cyc, cyc, MAXC);
      $fatal(1);
    end
    if (ack0) begin
      req0 = rearm0;
      if (!fixed_data) data0 = M'($urandom);
    end
    if (ack1) begin
      req1 = rearm1;
      if (!fixed_data) data1 = M'($urandom);
    end
  endtask

  // Monitor: pop one expected grant per ack and check per-cycle output state.
  always @(negedge clk) begin
    if (cyc >= 1 && !done) begin
      chk("ack_onehot", {31'd0, ack0 && ack1}, 32'd0);
      if (ack0 || ack1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
        end else begin
          mon_g = sb_q.pop_front();
          chk("ack_cycle", cyc, mon_g.cyc);
          chk("ack0", ack0, !mon_g.ch);
          chk("ack1", ack1, mon_g.ch);
          chk("grant_data", out_data, mon_g.data);
        end
      end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
        mon_g = sb_q.pop_front();
        chk("missing_ack", {30'd0, ack1, ack0}, mon_g.ch ? 32'd2 : 32'd1);
      end
      chk("out_valid", out_valid, exp_valid[cyc]);
      chk("busy", busy, exp_busy[cyc]);
      if (exp_valid[cyc]) begin
        chk("sel_hold", sel, exp_sel[cyc]);
        chk("out_data_hold", out_data, exp_data[cyc]);
      end
      if (exp_zero[cyc]) begin
        chk("rst_sel", sel, 1'b0);
        chk("rst_out_data", out_data, 12'h000);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout, expected $finish", cyc);
    $fatal(1);
  end

  initial begin
    m_pending = 1'b0; m_last = 1'b1; m_free = 0; m_dwell = 0; m_ch = 1'b0; m_data = '0;
    rearm0 = 1'b0; rearm1 = 1'b0; fixed_data = 1'b0;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; data0 = 12'h111; data1 = 12'h222;
    mode = 1'b0; dwell = 4'd0; out_ready = 1'b1;
    next(); next();

    // Single request
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    next(); next();
    req0 = 1'b1; data0 = 12'hA5C;
    repeat (4) next();

    // Round-robin from a fresh reset, then fixed priority
    rst_n = 1'b0; next();
    rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 12'h111; data1 = 12'h222;
    rearm0 = 1'b1; rearm1 = 1'b1; fixed_data = 1'b1; mode = 1'b0;
    repeat (10) next();
    mode = 1'b1;
    repeat (10) next();
    req0 = 1'b0; req1 = 1'b0; rearm0 = 1'b0; rearm1 = 1'b0; fixed_data = 1'b0; mode = 1'b0;
    repeat (3) next();

    // Backpressure while data0 keeps changing
    req0 = 1'b1; data0 = 12'h3C3; out_ready = 1'b0;
    next();
    repeat (6) begin
      if (!req0) data0 = M'($urandom);
      next();
    end
    out_ready = 1'b1;
    repeat (3) next();

    // Dwell between back-to-back grants
    dwell = 4'd3; req0 = 1'b1; req1 = 1'b1; rearm0 = 1'b1; rearm1 = 1'b1;
    repeat (16) next();
    req0 = 1'b0; req1 = 1'b0; rearm0 = 1'b0; rearm1 = 1'b0;
    repeat (6) next();

    // Reset during DWELL
    dwell = 4'd7; req0 = 1'b1;
    for (int i = 0; i < 10 && !ack0; i++) next();
    chk("abort_ack_seen", ack0, 1'b1);
    next(); next();
    rst_n = 1'b0; next();
    rst_n = 1'b1;
    repeat (3) next();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      mode      = 1'($urandom_range(0, 1));
      dwell     = ($urandom_range(0, 2) == 0) ? DW'($urandom) : 4'd0;
      out_ready = ($urandom_range(0, 3) != 0);
      rearm0    = 1'($urandom_range(0, 1));
      rearm1    = 1'($urandom_range(0, 1));
      if (!req0) begin
        if ($urandom_range(0, 2) == 0) begin req0 = 1'b1; data0 = M'($urandom); end
      end else if (!ack0 && $urandom_range(0, 19) == 0) begin
        req0 = 1'b0;
      end
      if (!req1) begin
        if ($urandom_range(0, 2) == 0) begin req1 = 1'b1; data1 = M'($urandom); end
      end else if (!ack1 && $urandom_range(0, 19) == 0) begin
        req1 = 1'b0;
      end
      next();
    end

    // Drain
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; rearm0 = 1'b0; rearm1 = 1'b0; out_ready = 1'b1;
    repeat (30) next();
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
